// File: rtl/remote_req_queue_pkg.sv
// Shared request types and helpers for the remote request queue.
package remote_req_queue_pkg;

  // Kind of remote request issued by the load/store unit.
  typedef enum logic [1:0] {
    e_req_store  = 2'd0,
    e_req_load   = 2'd1,
    e_req_amo    = 2'd2,
    e_req_icache = 2'd3
  } remote_req_op_e;

  // Request layout as seen at the LSU / network TX boundary.
  typedef struct packed {
    remote_req_op_e op;
    logic [3:0]     mask;
    logic [31:0]    addr;
    logic [31:0]    data;
  } remote_req_s;

  localparam int remote_req_width_gp = $bits(remote_req_s);

  // Increment a pointer and wrap at els; works for non-power-of-two depths.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned els);
    return (ptr + 1 == els) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/remote_req_fifo.sv
// Small 1r1w FIFO holding the queued requests and the read/write pointers.
// Occupancy is tracked by the parent; enq_i/deq_i must already be qualified.
module remote_req_fifo
  import remote_req_queue_pkg::*;
#(
  parameter int els_p       = 2,
  parameter int ptr_width_p = 1,
  parameter int width_p     = remote_req_width_gp
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enq_i,
  input  logic               deq_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0]     mem_r [els_p];
  logic [ptr_width_p-1:0] wptr_r;
  logic [ptr_width_p-1:0] rptr_r;

  // Advance pointers on qualified enqueue/dequeue, wrapping at els_p.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (enq_i) wptr_r <= ptr_width_p'(wrap_inc(32'(wptr_r), els_p));
      if (deq_i) rptr_r <= ptr_width_p'(wrap_inc(32'(rptr_r), els_p));
    end
  end

  // Per-entry storage; contents need no reset since validity lives in the parent.
  for (genvar gi = 0; gi < els_p; gi++) begin : g_entry
    always_ff @(posedge clk_i) begin
      if (enq_i && (wptr_r == ptr_width_p'(gi))) mem_r[gi] <= data_i;
    end
  end

  // Head entry is read straight from registered storage.
  assign data_o = mem_r[rptr_r];

endmodule

// File: rtl/remote_req_queue.sv
// Remote request queue between the LSU and network TX. Every queued entry
// reserves one outstanding-request credit, so the head is never presented
// to the network without a credit behind it.
module remote_req_queue
  import remote_req_queue_pkg::*;
#(
  parameter  int els_p             = 2,
  parameter  int max_out_credits_p = 32,
  localparam int credit_width_lp   = $clog2(max_out_credits_p+1),
  localparam int ptr_width_lp      = $clog2(els_p)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [$bits(remote_req_s)-1:0]   remote_req_i,
  input  logic                             remote_req_v_i,
  output logic                             ready_o,
  output logic [$bits(remote_req_s)-1:0]   remote_req_o,
  output logic                             remote_req_v_o,
  input  logic                             remote_req_yumi_i,
  input  logic                             credit_return_i,
  output logic [credit_width_lp-1:0]       out_credits_o,
  output logic                             fence_busy_o
);

  localparam int count_width_lp = $clog2(els_p+1);
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  logic [count_width_lp-1:0]  count_r;
  logic [credit_width_lp-1:0] credits_r;
  logic enq;
  logic deq;
  logic credit_inc;
  logic credit_overflow_err;
  logic yumi_empty_err;

  // Admission uses registered state only: room in the queue and a spare credit.
  assign ready_o = (int'(count_r) < els_p) && (int'(credits_r) > int'(count_r));

  assign remote_req_v_o = (count_r != '0);
  assign enq            = remote_req_v_i & ready_o;
  assign deq            = remote_req_yumi_i & remote_req_v_o;

  // A return at full credits is spurious and ignored, unless it pairs with a
  // dequeue in the same cycle, in which case the two cancel.
  assign credit_inc = credit_return_i & ((credits_r != max_credits_lp) | deq);

  assign credit_overflow_err = credit_return_i & (credits_r == max_credits_lp);
  assign yumi_empty_err      = remote_req_yumi_i & ~remote_req_v_o;

  assign out_credits_o = credits_r;
  assign fence_busy_o  = (count_r != '0) | (credits_r != max_credits_lp);

  // Track queue occupancy.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_r <= '0;
    end else if (enq & ~deq) begin
      count_r <= count_r + count_width_lp'(1);
    end else if (deq & ~enq) begin
      count_r <= count_r - count_width_lp'(1);
    end
  end

  // Consume a credit per dequeued request, restore one per network response.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      credits_r <= max_credits_lp;
    end else if (deq & ~credit_inc) begin
      credits_r <= credits_r - credit_width_lp'(1);
    end else if (credit_inc & ~deq) begin
      credits_r <= credits_r + credit_width_lp'(1);
    end
  end

  remote_req_fifo #(
    .els_p       (els_p),
    .ptr_width_p (ptr_width_lp),
    .width_p     ($bits(remote_req_s))
  ) fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .enq_i   (enq),
    .deq_i   (deq),
    .data_i  (remote_req_i),
    .data_o  (remote_req_o)
  );

`ifndef SYNTHESIS
  // Flag network-side protocol violations; the datapath ignores both.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      assert (!yumi_empty_err)
        else $error("remote_req_queue: yumi with no valid head");
      assert (!credit_overflow_err)
        else $warning("remote_req_queue: credit return at full credits ignored");
    end
  end
`endif

endmodule

// File: tb/tb_remote_req_queue.sv
// Scoreboard bench for remote_req_queue: a 32-credit instance and a 4-credit one.
module tb_remote_req_queue;
  import remote_req_queue_pkg::*;

  localparam int W = $bits(remote_req_s);

  logic clk = 1'b0;
  logic reset_i;

  logic [W-1:0] req_i, req_o;
  logic         v_i, ready_o, v_o, yumi_i, cret_i, fence_o;
  logic [5:0]   credits_o;

  logic [W-1:0] req4_i, req4_o;
  logic         v4_i, ready4_o, v4_o, yumi4_i, cret4_i, fence4_o;
  logic [2:0]   credits4_o;

  int n_cmp = 0;
  int n_err = 0;
  remote_req_s exp_q[$];
  remote_req_s exp_r;

  always #5 clk = ~clk;

  remote_req_queue #(.els_p(2), .max_out_credits_p(32)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .remote_req_i(req_i), .remote_req_v_i(v_i), .ready_o(ready_o),
    .remote_req_o(req_o), .remote_req_v_o(v_o), .remote_req_yumi_i(yumi_i),
    .credit_return_i(cret_i), .out_credits_o(credits_o), .fence_busy_o(fence_o)
  );

  remote_req_queue #(.els_p(2), .max_out_credits_p(4)) dut4 (
    .clk_i(clk), .reset_i(reset_i),
    .remote_req_i(req4_i), .remote_req_v_i(v4_i), .ready_o(ready4_o),
    .remote_req_o(req4_o), .remote_req_v_o(v4_o), .remote_req_yumi_i(yumi4_i),
    .credit_return_i(cret4_i), .out_credits_o(credits4_o), .fence_busy_o(fence4_o)
  );

  function automatic remote_req_s mk(input int i);
    remote_req_s r;
    r.op   = remote_req_op_e'(i % 4);
    r.mask = 4'(i + 1);
    r.addr = 32'h1000 + 32'(i) * 4;
    r.data = $urandom;
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    v_i = 0; yumi_i = 0; cret_i = 0; req_i = '0;
    v4_i = 0; yumi4_i = 0; cret4_i = 0; req4_i = '0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 reset_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    n_cmp++; if (credits_o !== 6'd32) begin n_err++; $display("FAIL reset_credits: got %0d want 32", credits_o); end
    n_cmp++; if (fence_o !== 1'b0) begin n_err++; $display("FAIL reset_fence: got %b want 0", fence_o); end
    n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", v_o); end
    $display("reset idle: ready=%b credits=%0d fence=%b v=%b", ready_o, credits_o, fence_o, v_o);
    next_cycle();
    // queue two entries, then reset between edges
    for (int c = 0; c < 2; c++) begin
      v_i = 1'b1; req_i = mk(c);
      next_cycle();
    end
    v_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (v_o !== 1'b1) begin n_err++; $display("FAIL prereset_valid: got %b want 1", v_o); end
    n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL prereset_full: got %b want 0", ready_o); end
    @(posedge clk);
    #3 reset_i = 1'b1;
    #1;
    n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b want 0", v_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL async_ready: got %b want 1", ready_o); end
    n_cmp++; if (credits_o !== 6'd32) begin n_err++; $display("FAIL async_credits: got %0d want 32", credits_o); end
    n_cmp++; if (fence_o !== 1'b0) begin n_err++; $display("FAIL async_fence: got %b want 0", fence_o); end
    $display("async reset mid-cycle: v=%b ready=%b credits=%0d fence=%b", v_o, ready_o, credits_o, fence_o);
    do_reset();
  endtask

  task automatic test_back_to_back();
    remote_req_s r;
    int idx = 0;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      v_i = (c < 10); yumi_i = (c > 0);
      r = mk(idx); req_i = r;
      @(negedge clk);
      n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready c%0d: got %b want 1", c, ready_o); end
      if (yumi_i) begin
        exp_r = exp_q.pop_front();
        n_cmp++; if (v_o !== 1'b1) begin n_err++; $display("FAIL b2b_valid c%0d: got %b want 1", c, v_o); end
        n_cmp++; if (req_o !== exp_r) begin n_err++; $display("FAIL b2b_head c%0d: got %h want %h", c, req_o, exp_r); end
        $display("b2b cycle %0d: dequeued addr=%h", c, req_o[63:32]);
      end
      if (v_i) begin exp_q.push_back(r); idx++; end
      next_cycle();
    end
    v_i = 0; yumi_i = 0;
    @(negedge clk);
    n_cmp++; if (credits_o !== 6'd22) begin n_err++; $display("FAIL b2b_credits: got %0d want 22", credits_o); end
    n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b want 0", v_o); end
    n_cmp++; if (fence_o !== 1'b1) begin n_err++; $display("FAIL b2b_fence: got %b want 1", fence_o); end
    next_cycle();
  endtask

  task automatic test_full();
    bit t_v   [7] = '{1,1,1,0,0,0,0};
    bit t_y   [7] = '{0,0,0,1,0,1,0};
    bit t_rdy [7] = '{1,1,0,0,1,1,1};
    bit t_vo  [7] = '{0,1,1,1,1,1,0};
    remote_req_s r;
    int idx = 100;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      v_i = t_v[c]; yumi_i = t_y[c];
      r = mk(idx); req_i = r;
      @(negedge clk);
      n_cmp++; if (ready_o !== t_rdy[c]) begin n_err++; $display("FAIL full_ready c%0d: got %b want %b", c, ready_o, t_rdy[c]); end
      n_cmp++; if (v_o !== t_vo[c]) begin n_err++; $display("FAIL full_valid c%0d: got %b want %b", c, v_o, t_vo[c]); end
      if (t_y[c]) begin
        exp_r = exp_q.pop_front();
        n_cmp++; if (req_o !== exp_r) begin n_err++; $display("FAIL full_head c%0d: got %h want %h", c, req_o, exp_r); end
      end
      if (t_v[c] && t_rdy[c]) begin exp_q.push_back(r); idx++; end
      $display("full cycle %0d: v_i=%b yumi=%b ready=%b v_o=%b", c, t_v[c], t_y[c], ready_o, v_o);
      next_cycle();
    end
    v_i = 0; yumi_i = 0;
  endtask

  task automatic test_credit_exhaust();
    bit t_v   [10] = '{1,1,1,1,1,1,1,0,0,0};
    bit t_y   [10] = '{0,1,1,1,0,0,0,1,1,0};
    bit t_cr  [10] = '{0,0,0,0,0,1,0,0,0,0};
    bit t_rdy [10] = '{1,1,1,1,0,0,1,0,0,0};
    bit t_vo  [10] = '{0,1,1,1,1,1,1,1,1,0};
    int t_cred[10] = '{4,4,3,2,1,1,2,2,1,0};
    remote_req_s r;
    int idx = 200;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      v4_i = t_v[c]; yumi4_i = t_y[c]; cret4_i = t_cr[c];
      r = mk(idx); req4_i = r;
      @(negedge clk);
      n_cmp++; if (ready4_o !== t_rdy[c]) begin n_err++; $display("FAIL cred_ready c%0d: got %b want %b", c, ready4_o, t_rdy[c]); end
      n_cmp++; if (credits4_o !== 3'(t_cred[c])) begin n_err++; $display("FAIL cred_count c%0d: got %0d want %0d", c, credits4_o, t_cred[c]); end
      n_cmp++; if (v4_o !== t_vo[c]) begin n_err++; $display("FAIL cred_valid c%0d: got %b want %b", c, v4_o, t_vo[c]); end
      if (t_y[c]) begin
        exp_r = exp_q.pop_front();
        n_cmp++; if (req4_o !== exp_r) begin n_err++; $display("FAIL cred_head c%0d: got %h want %h", c, req4_o, exp_r); end
      end
      if (t_v[c] && t_rdy[c]) begin exp_q.push_back(r); idx++; end
      $display("credit cycle %0d: ready=%b credits=%0d v_o=%b", c, ready4_o, credits4_o, v4_o);
      next_cycle();
    end
    v4_i = 0; yumi4_i = 0; cret4_i = 0;
    @(negedge clk);
    n_cmp++; if (fence4_o !== 1'b1) begin n_err++; $display("FAIL cred_fence: got %b want 1", fence4_o); end
    next_cycle();
  endtask

  task automatic test_simultaneous();
    remote_req_s r;
    int idx = 300;
    int exp_cred;
    do_reset();
    for (int c = 0; c <= 25; c++) begin
      v_i    = (c <= 21);
      yumi_i = (c >= 1 && c <= 22);
      cret_i = (c >= 2 && c <= 21) || c == 23 || c == 24;
      exp_cred = (c <= 1) ? 32 : (c <= 22) ? 31 : (c == 23) ? 30 : (c == 24) ? 31 : 32;
      r = mk(idx); req_i = r;
      @(negedge clk);
      n_cmp++; if (credits_o !== 6'(exp_cred)) begin n_err++; $display("FAIL sim_credits c%0d: got %0d want %0d", c, credits_o, exp_cred); end
      if (yumi_i) begin
        exp_r = exp_q.pop_front();
        n_cmp++; if (req_o !== exp_r) begin n_err++; $display("FAIL sim_head c%0d: got %h want %h", c, req_o, exp_r); end
      end
      if (c >= 24) begin
        n_cmp++; if (fence_o !== (c == 24)) begin n_err++; $display("FAIL sim_fence c%0d: got %b want %b", c, fence_o, c == 24); end
      end
      if (v_i) begin exp_q.push_back(r); idx++; end
      $display("simul cycle %0d: yumi=%b ret=%b credits=%0d fence=%b", c, yumi_i, cret_i, credits_o, fence_o);
      next_cycle();
    end
    v_i = 0; yumi_i = 0; cret_i = 0;
  endtask

  task automatic test_spurious_return();
    do_reset();
    cret_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (dut.credit_overflow_err !== 1'b1) begin n_err++; $display("FAIL spur_flag: got %b want 1", dut.credit_overflow_err); end
    next_cycle();
    cret_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (credits_o !== 6'd32) begin n_err++; $display("FAIL spur_credits: got %0d want 32", credits_o); end
    n_cmp++; if (fence_o !== 1'b0) begin n_err++; $display("FAIL spur_fence: got %b want 0", fence_o); end
    $display("spurious return: credits=%0d fence=%b", credits_o, fence_o);
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full();
    test_credit_exhaust();
    test_simultaneous();
    test_spurious_return();
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL leftover_expected: got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
